// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// default oversampling ratio and the majority-vote sample points.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned OVS    = 16;
  localparam int unsigned MID_LO = OVS / 2 - 1;
  localparam int unsigned MID    = OVS / 2;
  localparam int unsigned MID_HI = OVS / 2 + 1;

  // 2-of-3 majority used to judge every bit
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-clk registered pulse every DIV clocks,
// restartable so the tick phase can be aligned to a start edge.
module baud_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic iCLR,
  output logic oTICK
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (iCLR) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign oTICK = tick_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// 8N1 UART receiver with OVS-times oversampling and 2-of-3 majority voting
// around each bit centre; bad stop bits park the FSM in BREAK until idle.
module uart_rx_ovs #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
);

  import uart_pkg::*;

  localparam int unsigned DIV_RAW = (CLK_FREQ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (OVS > 1) ? $clog2(OVS) : 1;

  localparam logic [CNT_W-1:0] T_LO   = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] T_MID  = CNT_W'(OVS / 2);
  localparam logic [CNT_W-1:0] T_HI   = CNT_W'(OVS / 2 + 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(OVS - 1);

  logic rx_meta_q, rx_s_q;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] ovs_q, ovs_d, ovs_inc;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       vote_q, vote_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;

  logic tick;
  logic tick_clr_c;
  logic active, at_lo, at_mid, at_hi, at_last, maj;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= iRX;
      rx_s_q    <= rx_meta_q;
    end
  end

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .iCLR  (tick_clr_c),
    .oTICK (tick)
  );

  // Decode of the tick that is about to land; ovs_inc is its index within the bit
  always_comb begin
    ovs_inc = (ovs_q == T_LAST) ? '0 : ovs_q + CNT_W'(1);
    active  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    at_lo   = tick && (ovs_inc == T_LO);
    at_mid  = tick && (ovs_inc == T_MID);
    at_hi   = tick && (ovs_inc == T_HI);
    at_last = tick && (ovs_inc == T_LAST);
    maj     = maj3(vote_q[0], vote_q[1], rx_s_q);
  end

  always_comb begin
    state_d    = state_q;
    ovs_d      = ovs_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    vote_d     = vote_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tick_clr_c = 1'b0;

    if (active && tick) begin
      ovs_d = ovs_inc;
    end
    if (active && at_lo) begin
      vote_d[0] = rx_s_q;
    end
    if (active && at_mid) begin
      vote_d[1] = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d    = ST_START;
          ovs_d      = '0;
          bit_d      = '0;
          vote_d     = '0;
          tick_clr_c = 1'b1;
        end
      end
      ST_START: begin
        // Two high samples already settle the vote, so drop a glitch early
        if (at_mid && vote_q[0] && rx_s_q) begin
          state_d = ST_IDLE;
        end else if (at_hi && maj) begin
          state_d = ST_IDLE;
        end else if (at_last) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_hi) begin
          shift_d = {maj, shift_q[7:1]};
        end
        if (at_last) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'(1);
          end
        end
      end
      ST_STOP: begin
        if (at_hi) begin
          if (maj) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ovs_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vote_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ovs_q   <= ovs_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vote_q  <= vote_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign oDATA      = data_q;
  assign oVALID     = valid_q;
  assign oFRAME_ERR = ferr_q;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: a frame-level model predicts every pulse
// (kind, payload, arrival window) and the held oDATA value each cycle.
module tb_uart_rx_ovs;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned OVS      = 16;
  localparam int unsigned DIV      = 10;
  localparam int unsigned BIT_CLKS = OVS * DIV;
  localparam int unsigned LAT      = 1531;
  localparam int unsigned TOL      = 10;

  typedef struct {
    int unsigned t;
    logic        good;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       iRX;
  logic [7:0] oDATA;
  logic       oVALID;
  logic       oFRAME_ERR;
  logic       oBUSY;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  int          n_ferr = 0;
  logic [7:0]  model_data = 8'h00;
  exp_t        exp_q[$];

  uart_rx_ovs #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iRX        (iRX),
    .oDATA      (oDATA),
    .oVALID     (oVALID),
    .oFRAME_ERR (oFRAME_ERR),
    .oBUSY      (oBUSY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      model_data = 8'h00;
      exp_q.delete();
      check("rst_valid", 32'(oVALID), 32'd0);
      check("rst_ferr", 32'(oFRAME_ERR), 32'd0);
      check("rst_data", 32'(oDATA), 32'd0);
    end else begin
      check("pulse_exclusive", 32'(oVALID & oFRAME_ERR), 32'd0);
      if (oVALID) n_valid++;
      if (oFRAME_ERR) n_ferr++;
      if (oVALID || oFRAME_ERR) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b at cycle %0d, no pulse required",
                   oVALID, oFRAME_ERR, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_valid", 32'(oVALID), 32'(e.good));
          n_checks++;
          if (cyc + TOL < e.t || cyc > e.t + TOL) begin
            n_fail++;
            $display("FAIL pulse_time: got cycle %0d, required %0d +/- %0d", cyc, e.t, TOL);
          end
          if (e.good) begin
            check("pulse_data", 32'(oDATA), 32'(e.data));
            model_data = e.data;
          end else begin
            check("ferr_data_held", 32'(oDATA), 32'(model_data));
          end
        end
      end else begin
        check("data_held", 32'(oDATA), 32'(model_data));
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].t + TOL) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: no pulse by cycle %0d, required at %0d", cyc, exp_q[0].t);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int i = 0; i < int'(BIT_CLKS); i++) begin
      iRX = (glitch && i == int'(BIT_CLKS / 2)) ? 1'b0 : v;
      step(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit glitch);
    exp_t e;
    e.t    = cyc + LAT;
    e.good = stop_v;
    e.data = d;
    exp_q.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(d[b], glitch);
    drive_bit(stop_v, 1'b0);
  endtask

  task automatic idle(input int n);
    iRX = 1'b1;
    step(n);
  endtask

  initial begin
    int v0;
    int f0;
    int unsigned t0;
    bit ok;

    reset = 1'b0;
    iRX   = 1'b1;
    step(5);
    check("reset_busy", 32'(oBUSY), 32'd0);
    check("reset_data", 32'(oDATA), 32'h00);
    reset = 1'b1;
    idle(20);

    // Single good frame
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h41, 1'b1, 1'b0);
    idle(20);
    check("f41_data", 32'(oDATA), 32'h41);
    check("f41_nvalid", 32'(n_valid - v0), 32'd1);
    check("f41_nferr", 32'(n_ferr - f0), 32'd0);

    // Start-bit glitch of 30 clocks
    v0 = n_valid; f0 = n_ferr;
    t0 = cyc;
    iRX = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) check("glitch_busy_rise", 32'(oBUSY), 32'd1);
      step(1);
    end
    iRX = 1'b1;
    ok = 1'b0;
    while (cyc - t0 <= 90) begin
      if (!oBUSY) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check("glitch_busy_drop", 32'(ok), 32'd1);
    idle(200);
    check("glitch_nvalid", 32'(n_valid - v0), 32'd0);
    check("glitch_nferr", 32'(n_ferr - f0), 32'd0);
    check("glitch_data", 32'(oDATA), 32'h41);

    // Bad stop bit followed by a long break
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h7E, 1'b0, 1'b0);
    iRX = 1'b0;
    step(2000);
    check("break_busy", 32'(oBUSY), 32'd1);
    check("break_nferr", 32'(n_ferr - f0), 32'd1);
    check("break_nvalid", 32'(n_valid - v0), 32'd0);
    check("break_data", 32'(oDATA), 32'h41);
    idle(10);
    check("break_exit_busy", 32'(oBUSY), 32'd0);
    idle(50);

    // Back-to-back frames, no idle gap
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0);
    idle(20);
    check("b2b_nvalid", 32'(n_valid - v0), 32'd2);
    check("b2b_nferr", 32'(n_ferr - f0), 32'd0);
    check("b2b_data", 32'(oDATA), 32'hAA);

    // Reset in data bit 4 of 0xC3
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, 1'b0);
    for (int b = 0; b < 4; b++) drive_bit((b < 2) ? 1'b1 : 1'b0, 1'b0);
    iRX = 1'b0;
    step(80);
    reset = 1'b0;
    step(3);
    check("abort_data", 32'(oDATA), 32'h00);
    check("abort_busy", 32'(oBUSY), 32'd0);
    check("abort_valid", 32'(oVALID), 32'd0);
    check("abort_ferr", 32'(oFRAME_ERR), 32'd0);
    iRX = 1'b1;
    step(3);
    reset = 1'b1;
    idle(200);
    check("abort_idle_busy", 32'(oBUSY), 32'd0);
    check("abort_nvalid", 32'(n_valid - v0), 32'd0);
    check("abort_nferr", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("after_abort_data", 32'(oDATA), 32'h3C);
    check("after_abort_nvalid", 32'(n_valid - v0), 32'd1);

    // One-clock low glitch mid-bit in every data bit of 0xFF
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(20);
    check("vote_data", 32'(oDATA), 32'hFF);
    check("vote_nvalid", 32'(n_valid - v0), 32'd1);
    check("vote_nferr", 32'(n_ferr - f0), 32'd0);

    idle(50);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
